// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, an iterative shift-add multiplier and
// the EX/MEM pipeline register. The multiplier holds the upstream stages via Ex_Stall.
module ex_stage #(
    parameter int width      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IdEx_RegDst,
    input  logic             IdEx_Branch,
    input  logic             IdEx_MemRead,
    input  logic             IdEx_MemtoReg,
    input  logic             IdEx_MemWrite,
    input  logic             IdEx_ALU_Src,
    input  logic             IdEx_RegWrite,
    input  logic [1:0]       IdEx_Alu_Op,
    input  logic [width-1:0] IdEx_DataRs,
    input  logic [width-1:0] IdEx_DataRt,
    input  logic [31:0]      IdEx_IMM_EX,
    input  logic [4:0]       IdEx_AddrRt,
    input  logic [4:0]       IdEx_AddrRd,
    input  logic [width-1:0] MemWbFwdData,
    input  logic [1:0]       Fwd_Rs,
    input  logic [1:0]       Fwd_Rt,
    input  logic             Flush,
    output logic             Ex_Stall,
    output logic             ExMem_Branch,
    output logic             ExMem_MemRead,
    output logic             ExMem_MemtoReg,
    output logic             ExMem_MemWrite,
    output logic             ExMem_RegWrite,
    output logic             ExMem_Zero,
    output logic [width-1:0] ExMem_AluResult,
    output logic [width-1:0] ExMem_StoreData,
    output logic [4:0]       ExMem_AddrRegWr,
    output logic             Dbg_MulBusy
);
    localparam int CW = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [width-1:0] acc_q, mcand_q, mplier_q;

    logic [width-1:0] op_a, op_bf, op_b, imm_w, alu_res, acc_d, result_d;
    logic [5:0]       funct;
    logic [4:0]       shamt;
    logic             mult_det, mul_last;

    assign imm_w = width'(IdEx_IMM_EX);
    assign funct = IdEx_IMM_EX[5:0];
    assign shamt = IdEx_IMM_EX[10:6];

    // Fwd=10 selects the registered EX/MEM result, so there is no combinational loop.
    always_comb begin
        case (Fwd_Rs)
            2'b01:   op_a = MemWbFwdData;
            2'b10:   op_a = ExMem_AluResult;
            default: op_a = IdEx_DataRs;
        endcase
        case (Fwd_Rt)
            2'b01:   op_bf = MemWbFwdData;
            2'b10:   op_bf = ExMem_AluResult;
            default: op_bf = IdEx_DataRt;
        endcase
    end

    assign op_b = IdEx_ALU_Src ? imm_w : op_bf;

    always_comb begin
        alu_res = '0;
        case (IdEx_Alu_Op)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b11: alu_res = op_a | op_b;
            default: begin
                case (funct)
                    6'h20:   alu_res = op_a + op_b;
                    6'h22:   alu_res = op_a - op_b;
                    6'h24:   alu_res = op_a & op_b;
                    6'h25:   alu_res = op_a | op_b;
                    6'h2A:   alu_res = {{(width-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                    6'h00:   alu_res = op_bf << shamt;
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

    assign mult_det = (IdEx_Alu_Op == 2'b10) && (funct == 6'h18) && IdEx_RegWrite;
    assign mul_last = (state_q == S_MUL) && (cnt_q == CNT_LAST);
    assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign result_d = mul_last ? acc_d : alu_res;

    // Ex_Stall high: IF/ID and ID/EX must hold; EX/MEM takes a bubble that cycle.
    // It is dropped on the last multiply iteration so the mult retires with its controls.
    assign Ex_Stall = !RST && !Flush &&
                      (((state_q == S_IDLE) && mult_det) ||
                       ((state_q == S_MUL) && (cnt_q != CNT_LAST)));

    assign Dbg_MulBusy = (state_q == S_MUL);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            acc_q           <= '0;
            mcand_q         <= '0;
            mplier_q        <= '0;
            ExMem_Branch    <= 1'b0;
            ExMem_MemRead   <= 1'b0;
            ExMem_MemtoReg  <= 1'b0;
            ExMem_MemWrite  <= 1'b0;
            ExMem_RegWrite  <= 1'b0;
            ExMem_Zero      <= 1'b0;
            ExMem_AluResult <= '0;
            ExMem_StoreData <= '0;
            ExMem_AddrRegWr <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mult_det && !Flush) begin
                        acc_q    <= '0;
                        mcand_q  <= op_a;
                        mplier_q <= op_bf;
                        cnt_q    <= '0;
                        state_q  <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (Flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (Flush || Ex_Stall) begin
                ExMem_Branch   <= 1'b0;
                ExMem_MemRead  <= 1'b0;
                ExMem_MemtoReg <= 1'b0;
                ExMem_MemWrite <= 1'b0;
                ExMem_RegWrite <= 1'b0;
            end else begin
                ExMem_Branch    <= IdEx_Branch;
                ExMem_MemRead   <= IdEx_MemRead;
                ExMem_MemtoReg  <= IdEx_MemtoReg;
                ExMem_MemWrite  <= IdEx_MemWrite;
                ExMem_RegWrite  <= IdEx_RegWrite;
                ExMem_Zero      <= (result_d == '0);
                ExMem_AluResult <= result_d;
                ExMem_StoreData <= op_bf;
                ExMem_AddrRegWr <= IdEx_RegDst ? IdEx_AddrRd : IdEx_AddrRt;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized instructions checked
// against an arithmetic reference model of the execute stage.
module tb_ex_stage;
    logic        CLK = 1'b0;
    logic        RST;
    logic        IdEx_RegDst, IdEx_Branch, IdEx_MemRead, IdEx_MemtoReg;
    logic        IdEx_MemWrite, IdEx_ALU_Src, IdEx_RegWrite;
    logic [1:0]  IdEx_Alu_Op;
    logic [31:0] IdEx_DataRs, IdEx_DataRt, IdEx_IMM_EX, MemWbFwdData;
    logic [4:0]  IdEx_AddrRt, IdEx_AddrRd;
    logic [1:0]  Fwd_Rs, Fwd_Rt;
    logic        Flush;
    logic        Ex_Stall;
    logic        ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg, ExMem_MemWrite, ExMem_RegWrite;
    logic        ExMem_Zero;
    logic [31:0] ExMem_AluResult, ExMem_StoreData;
    logic [4:0]  ExMem_AddrRegWr;
    logic        Dbg_MulBusy;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_res;   // model of the EX/MEM result, used for Fwd=10

    ex_stage #(.width(32), .MUL_CYCLES(32)) dut (
        .CLK(CLK), .RST(RST),
        .IdEx_RegDst(IdEx_RegDst), .IdEx_Branch(IdEx_Branch), .IdEx_MemRead(IdEx_MemRead),
        .IdEx_MemtoReg(IdEx_MemtoReg), .IdEx_MemWrite(IdEx_MemWrite), .IdEx_ALU_Src(IdEx_ALU_Src),
        .IdEx_RegWrite(IdEx_RegWrite), .IdEx_Alu_Op(IdEx_Alu_Op),
        .IdEx_DataRs(IdEx_DataRs), .IdEx_DataRt(IdEx_DataRt), .IdEx_IMM_EX(IdEx_IMM_EX),
        .IdEx_AddrRt(IdEx_AddrRt), .IdEx_AddrRd(IdEx_AddrRd), .MemWbFwdData(MemWbFwdData),
        .Fwd_Rs(Fwd_Rs), .Fwd_Rt(Fwd_Rt), .Flush(Flush), .Ex_Stall(Ex_Stall),
        .ExMem_Branch(ExMem_Branch), .ExMem_MemRead(ExMem_MemRead), .ExMem_MemtoReg(ExMem_MemtoReg),
        .ExMem_MemWrite(ExMem_MemWrite), .ExMem_RegWrite(ExMem_RegWrite), .ExMem_Zero(ExMem_Zero),
        .ExMem_AluResult(ExMem_AluResult), .ExMem_StoreData(ExMem_StoreData),
        .ExMem_AddrRegWr(ExMem_AddrRegWr), .Dbg_MulBusy(Dbg_MulBusy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] reg_v);
        if (sel == 2'b01) return MemWbFwdData;
        if (sel == 2'b10) return m_res;
        return reg_v;
    endfunction

    function automatic logic [31:0] ref_result();
        logic [31:0] a, bf, b;
        int sh;
        a  = fwd_val(Fwd_Rs, IdEx_DataRs);
        bf = fwd_val(Fwd_Rt, IdEx_DataRt);
        b  = IdEx_ALU_Src ? IdEx_IMM_EX : bf;
        sh = int'(IdEx_IMM_EX[10:6]);
        if (IdEx_Alu_Op == 2'b00) return a + b;
        if (IdEx_Alu_Op == 2'b01) return a - b;
        if (IdEx_Alu_Op == 2'b11) return a | b;
        case (IdEx_IMM_EX[5:0])
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00: return bf << sh;
            6'h18: return IdEx_RegWrite ? a * bf : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic clear_inputs();
        IdEx_RegDst = 0; IdEx_Branch = 0; IdEx_MemRead = 0; IdEx_MemtoReg = 0;
        IdEx_MemWrite = 0; IdEx_ALU_Src = 0; IdEx_RegWrite = 0; IdEx_Alu_Op = 2'b00;
        IdEx_DataRs = 0; IdEx_DataRt = 0; IdEx_IMM_EX = 0; MemWbFwdData = 0;
        IdEx_AddrRt = 0; IdEx_AddrRd = 0; Fwd_Rs = 0; Fwd_Rt = 0; Flush = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_mult(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        clear_inputs();
        IdEx_Alu_Op = 2'b10; IdEx_IMM_EX = 32'h18; IdEx_RegWrite = 1;
        IdEx_RegDst = 1; IdEx_AddrRd = rd; IdEx_DataRs = a; IdEx_DataRt = b;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if ({ExMem_AluResult, ExMem_StoreData, ExMem_AddrRegWr, ExMem_Zero, ExMem_RegWrite,
             ExMem_Branch, ExMem_MemWrite, Ex_Stall} !== '0) begin
            errors++;
            $display("FAIL reset_state: got res=%0h sd=%0h stall=%0b required all 0",
                     ExMem_AluResult, ExMem_StoreData, Ex_Stall);
        end
        RST = 0;
        clear_inputs();
        IdEx_Alu_Op = 2'b00; IdEx_DataRs = 32'h11; IdEx_DataRt = 32'h22;
        IdEx_RegWrite = 1; IdEx_RegDst = 1; IdEx_AddrRd = 5'd6;
        tick();
        checks++;
        if (ExMem_AluResult !== 32'h33) begin
            errors++;
            $display("FAIL pre_reset_add: got %0h required 33", ExMem_AluResult);
        end
        // asynchronous reset in the middle of a cycle
        #3 RST = 1;
        #1;
        checks++;
        if ({ExMem_AluResult, ExMem_AddrRegWr, ExMem_RegWrite, Ex_Stall} !== '0) begin
            errors++;
            $display("FAIL async_reset: got res=%0h addr=%0d rw=%0b stall=%0b required 0",
                     ExMem_AluResult, ExMem_AddrRegWr, ExMem_RegWrite, Ex_Stall);
        end
        clear_inputs();
        RST = 0;
        tick();
        m_res = 32'h0;
    endtask

    task automatic test_add();
        clear_inputs();
        IdEx_Alu_Op = 2'b10; IdEx_IMM_EX = 32'h20; IdEx_DataRs = 5; IdEx_DataRt = 7;
        IdEx_RegDst = 1; IdEx_AddrRd = 5'd3; IdEx_AddrRt = 5'd9; IdEx_RegWrite = 1;
        tick();
        checks++;
        if (ExMem_AluResult !== 32'd12) begin
            errors++; $display("FAIL add_result: got %0h required c", ExMem_AluResult);
        end
        checks++;
        if (ExMem_AddrRegWr !== 5'd3 || ExMem_Zero !== 1'b0 || ExMem_RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL add_fields: got addr=%0d zero=%0b rw=%0b required 3 0 1",
                     ExMem_AddrRegWr, ExMem_Zero, ExMem_RegWrite);
        end
        m_res = 32'd12;
    endtask

    task automatic test_fwd_beq();
        clear_inputs();
        IdEx_Alu_Op = 2'b00; IdEx_DataRs = 4; IdEx_DataRt = 5; IdEx_RegWrite = 1;
        tick();
        m_res = 32'd9;
        clear_inputs();
        Fwd_Rs = 2'b10; IdEx_DataRs = 32'hDEAD_BEEF;
        Fwd_Rt = 2'b01; MemWbFwdData = 32'd9; IdEx_DataRt = 32'h1;
        IdEx_Alu_Op = 2'b01; IdEx_Branch = 1;
        tick();
        checks++;
        if (ExMem_Zero !== 1'b1 || ExMem_Branch !== 1'b1 || ExMem_AluResult !== 32'd0) begin
            errors++;
            $display("FAIL beq_fwd: got zero=%0b br=%0b res=%0h required 1 1 0",
                     ExMem_Zero, ExMem_Branch, ExMem_AluResult);
        end
        m_res = 32'd0;
        clear_inputs();
        IdEx_Alu_Op = 2'b10; IdEx_IMM_EX = 32'h2A; IdEx_DataRs = 32'hFFFF_FFFF; IdEx_DataRt = 1;
        IdEx_RegWrite = 1;
        tick();
        checks++;
        if (ExMem_AluResult !== 32'd1 || ExMem_Zero !== 1'b0) begin
            errors++; $display("FAIL slt_neg: got %0h required 1", ExMem_AluResult);
        end
        IdEx_DataRs = 1; IdEx_DataRt = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (ExMem_AluResult !== 32'd0 || ExMem_Zero !== 1'b1) begin
            errors++; $display("FAIL slt_pos: got %0h zero=%0b required 0 1", ExMem_AluResult, ExMem_Zero);
        end
        IdEx_IMM_EX = (32'd4 << 6); IdEx_DataRt = 32'h8000_0003;
        tick();
        checks++;
        if (ExMem_AluResult !== 32'h0000_0030) begin
            errors++; $display("FAIL sll: got %0h required 30", ExMem_AluResult);
        end
        IdEx_IMM_EX = 32'h3F; IdEx_DataRs = 32'h77;
        tick();
        checks++;
        if (ExMem_AluResult !== 32'd0) begin
            errors++; $display("FAIL unknown_funct: got %0h required 0", ExMem_AluResult);
        end
        m_res = 32'd0;
    endtask

    task automatic test_load_store();
        clear_inputs();
        IdEx_Alu_Op = 2'b00; IdEx_ALU_Src = 1; IdEx_DataRs = 32'h100; IdEx_IMM_EX = 32'hFFFF_FFFC;
        IdEx_DataRt = 32'h55; IdEx_MemWrite = 1; IdEx_AddrRt = 5'd12;
        tick();
        checks++;
        if (ExMem_AluResult !== 32'hFC || ExMem_StoreData !== 32'h55 || ExMem_MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL store: got addr=%0h sd=%0h mw=%0b required fc 55 1",
                     ExMem_AluResult, ExMem_StoreData, ExMem_MemWrite);
        end
        m_res = 32'hFC;
        clear_inputs();
        IdEx_Alu_Op = 2'b00; IdEx_ALU_Src = 1; IdEx_DataRs = 32'h200; IdEx_IMM_EX = 32'h8;
        IdEx_MemRead = 1; IdEx_MemtoReg = 1; IdEx_RegWrite = 1; IdEx_AddrRt = 5'd17; IdEx_AddrRd = 5'd2;
        tick();
        checks++;
        if (ExMem_AluResult !== 32'h208 || ExMem_AddrRegWr !== 5'd17 ||
            {ExMem_MemRead, ExMem_MemtoReg, ExMem_RegWrite} !== 3'b111) begin
            errors++;
            $display("FAIL load: got addr=%0h wr=%0d required 208 17", ExMem_AluResult, ExMem_AddrRegWr);
        end
        m_res = 32'h208;
    endtask

    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp;
        int stall_cyc, edges;
        logic bad_rw;
        drive_mult(a, b, rd);
        exp = ref_result();
        #1;
        stall_cyc = 0; edges = 0; bad_rw = 0;
        while (Ex_Stall === 1'b1 && edges < 40) begin
            stall_cyc++;
            tick();
            edges++;
            if (ExMem_RegWrite !== 1'b0) bad_rw = 1;
        end
        tick();
        edges++;
        checks++;
        if (stall_cyc != 32 || edges != 33) begin
            errors++;
            $display("FAIL mult_timing: got stall=%0d edges=%0d required 32 33", stall_cyc, edges);
        end
        checks++;
        if (bad_rw) begin
            errors++; $display("FAIL mult_bubble: got RegWrite=1 during stall required 0");
        end
        checks++;
        if (ExMem_AluResult !== exp || ExMem_RegWrite !== 1'b1 || ExMem_AddrRegWr !== rd ||
            ExMem_Zero !== (exp == 32'd0)) begin
            errors++;
            $display("FAIL mult_result: got %0h rw=%0b addr=%0d zero=%0b required %0h 1 %0d %0b",
                     ExMem_AluResult, ExMem_RegWrite, ExMem_AddrRegWr, ExMem_Zero, exp, rd, exp == 0);
        end
        m_res = exp;
    endtask

    task automatic test_mult();
        run_mult(32'h0001_0003, 32'h0000_0010, 5'd8);
        checks++;
        if (ExMem_AluResult !== 32'h0010_0030) begin
            errors++; $display("FAIL mult_spec_value: got %0h required 100030", ExMem_AluResult);
        end
        run_mult(32'd0, $urandom, 5'd4);
        for (int i = 0; i < 3; i++) run_mult($urandom, $urandom, 5'($urandom_range(1, 31)));
        clear_inputs();
        tick();
        m_res = 32'd0;
    endtask

    task automatic test_flush_mult();
        drive_mult(32'd3, 32'd5, 5'd10);
        #1;
        repeat (11) tick();
        checks++;
        if (Dbg_MulBusy !== 1'b1 || Ex_Stall !== 1'b1) begin
            errors++; $display("FAIL flush_pre: got busy=%0b stall=%0b required 1 1", Dbg_MulBusy, Ex_Stall);
        end
        Flush = 1;
        #1;
        checks++;
        if (Ex_Stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall: got %0b required 0", Ex_Stall);
        end
        tick();
        checks++;
        if ({ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg, ExMem_MemWrite, ExMem_RegWrite} !== 5'b0 ||
            Dbg_MulBusy !== 1'b0) begin
            errors++;
            $display("FAIL flush_ctl: got rw=%0b busy=%0b required 0 0", ExMem_RegWrite, Dbg_MulBusy);
        end
        clear_inputs();
        IdEx_Alu_Op = 2'b00; IdEx_DataRs = 2; IdEx_DataRt = 3; IdEx_RegWrite = 1; IdEx_AddrRt = 5'd9;
        #1;
        checks++;
        if (Ex_Stall !== 1'b0) begin
            errors++; $display("FAIL flush_next_stall: got %0b required 0", Ex_Stall);
        end
        tick();
        checks++;
        if (ExMem_AluResult !== 32'd5 || ExMem_RegWrite !== 1'b1 || ExMem_AddrRegWr !== 5'd9) begin
            errors++;
            $display("FAIL flush_next_add: got %0h rw=%0b addr=%0d required 5 1 9",
                     ExMem_AluResult, ExMem_RegWrite, ExMem_AddrRegWr);
        end
        m_res = 32'd5;
    endtask

    task automatic test_reset_mid_mul();
        bit seen_rw;
        drive_mult(32'h1234, 32'h99, 5'd11);
        #1;
        repeat (5) tick();
        #3 RST = 1;
        #1;
        checks++;
        if (Ex_Stall !== 1'b0 || Dbg_MulBusy !== 1'b0 || ExMem_AluResult !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_mul: got stall=%0b busy=%0b res=%0h required 0 0 0",
                     Ex_Stall, Dbg_MulBusy, ExMem_AluResult);
        end
        clear_inputs();
        RST = 0;
        seen_rw = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ExMem_RegWrite !== 1'b0 || Dbg_MulBusy !== 1'b0) seen_rw = 1;
        end
        checks++;
        if (seen_rw) begin
            errors++; $display("FAIL reset_no_result: got late write or busy required none");
        end
        m_res = 32'd0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] prod;
        run_mult(32'h0000_1234, 32'h0000_0010, 5'd7);
        prod = m_res;
        clear_inputs();
        IdEx_Alu_Op = 2'b00; Fwd_Rs = 2'b10; IdEx_DataRs = 32'hBAD0_BAD0; IdEx_DataRt = 1;
        IdEx_RegWrite = 1;
        tick();
        checks++;
        if (ExMem_AluResult !== prod + 32'd1) begin
            errors++; $display("FAIL b2b_fwd: got %0h required %0h", ExMem_AluResult, prod + 32'd1);
        end
        m_res = prod + 32'd1;
    endtask

    task automatic test_random();
        logic [5:0] functs [7];
        logic [31:0] exp_res, exp_sd;
        logic [4:0] exp_addr;
        logic [4:0] exp_ctl;
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h3F};
        for (int i = 0; i < 60; i++) begin
            clear_inputs();
            IdEx_Alu_Op   = 2'($urandom_range(0, 3));
            IdEx_IMM_EX   = $urandom;
            if (IdEx_Alu_Op == 2'b10) IdEx_IMM_EX[5:0] = functs[$urandom_range(0, 6)];
            IdEx_DataRs   = $urandom;
            IdEx_DataRt   = ($urandom_range(0, 3) == 0) ? IdEx_DataRs : $urandom;
            MemWbFwdData  = $urandom;
            Fwd_Rs        = 2'($urandom_range(0, 3));
            Fwd_Rt        = 2'($urandom_range(0, 3));
            IdEx_ALU_Src  = 1'($urandom_range(0, 1));
            {IdEx_RegDst, IdEx_Branch, IdEx_MemRead, IdEx_MemtoReg, IdEx_MemWrite, IdEx_RegWrite}
                          = 6'($urandom_range(0, 63));
            IdEx_AddrRt   = 5'($urandom_range(0, 31));
            IdEx_AddrRd   = 5'($urandom_range(0, 31));
            exp_res  = ref_result();
            exp_sd   = fwd_val(Fwd_Rt, IdEx_DataRt);
            exp_addr = IdEx_RegDst ? IdEx_AddrRd : IdEx_AddrRt;
            exp_ctl  = {IdEx_Branch, IdEx_MemRead, IdEx_MemtoReg, IdEx_MemWrite, IdEx_RegWrite};
            tick();
            checks++;
            if (ExMem_AluResult !== exp_res || ExMem_Zero !== (exp_res == 32'd0)) begin
                errors++;
                $display("FAIL rand_result[%0d]: op=%0d funct=%0h got %0h zero=%0b required %0h",
                         i, IdEx_Alu_Op, IdEx_IMM_EX[5:0], ExMem_AluResult, ExMem_Zero, exp_res);
            end
            checks++;
            if (ExMem_StoreData !== exp_sd || ExMem_AddrRegWr !== exp_addr ||
                {ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg, ExMem_MemWrite, ExMem_RegWrite} !== exp_ctl) begin
                errors++;
                $display("FAIL rand_fields[%0d]: got sd=%0h addr=%0d required sd=%0h addr=%0d ctl=%b",
                         i, ExMem_StoreData, ExMem_AddrRegWr, exp_sd, exp_addr, exp_ctl);
            end
            m_res = exp_res;
        end
    endtask

    initial begin
        RST = 1;
        m_res = 32'd0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_add();
        test_fwd_beq();
        test_load_store();
        test_mult();
        test_flush_mult();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
